// File: rtl/and_serial16.sv
// Bit-serial bitwise AND with a valid/ready handshake on both sides.
// Each operand pair takes WIDTH SHIFT cycles, one bit per cycle, LSB first.
module and_serial16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-2:0]   res_q;
  logic [WIDTH-1:0]   out_q;
  logic               out_valid_q;

  logic               bit_and;
  logic [WIDTH-1:0]   res_cat;

  // Single shared 1-bit AND; the new bit enters the partial result from the MSB end.
  always_comb begin
    bit_and = a_q[0] & b_q[0];
    res_cat = {bit_and, res_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            cnt_q   <= '0;
            state_q <= StShift;
          end
        end
        StShift: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_cat[WIDTH-1:1];
          if (cnt_q == LastCnt) begin
            // Final bit: publish the full result, which stays put until the next completion.
            cnt_q       <= '0;
            out_q       <= res_cat;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule
